// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared constants and helpers for the parameterised synchronous FIFO.
//   DWIDTH_DEF / DEPTH_DEF / AE_LEVEL_DEF / IN_REG_DEF : default parameter values
//   AF_MARGIN_DEF : distance below DEPTH at which almost_full asserts by default
//   clog2_f()     : ceiling log2, used for pointer (clog2) and level (clog2+1) widths
package sfifo_pkg;

    localparam int DWIDTH_DEF    = 8;
    localparam int DEPTH_DEF     = 64;
    localparam int AF_MARGIN_DEF = 4;
    localparam int AE_LEVEL_DEF  = 4;
    localparam int IN_REG_DEF    = 1;

    // Ceiling log2; usable in constant (parameter) context.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sfifo_param_if.sv
// sfifo_param_if: request/response and status bundle of the FIFO.
//   master : drives w_en, din, r_en, err_clr; observes data and status
//   slave  : the FIFO side (inverse directions)
//   dout/dout_valid : read data and one-cycle "dout updated" pulse
//   full/empty/almost_full/almost_empty/level : registered occupancy status
//   overflow/underflow : sticky error flags, cleared by err_clr
interface sfifo_param_if
    import sfifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) ();

    localparam int LW = clog2_f(DEPTH) + 1;

    logic              w_en;
    logic [DWIDTH-1:0] din;
    logic              r_en;
    logic              err_clr;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              underflow;

    modport master (
        output w_en, din, r_en, err_clr,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  w_en, din, r_en, err_clr,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

endinterface

// File: rtl/sfifo_mem.sv
// sfifo_mem: DEPTH x DWIDTH storage, one write port and one registered read port.
//   clk, rst            : clock, async active-low reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i : write port
//   rd_en_i/rd_addr_i   : read request; rd_data_o updates on the same edge
//   rd_data_o           : registered read data, holds when rd_en_i is low
// A read and a write to the same address on one edge return the old word.
module sfifo_mem
    import sfifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [clog2_f(DEPTH)-1:0]  wr_addr_i,
    input  logic [DWIDTH-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    input  logic [clog2_f(DEPTH)-1:0]  rd_addr_i,
    output logic [DWIDTH-1:0]          rd_data_o
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rd_data_q;

    // Storage array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; cleared by reset so dout starts at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= {DWIDTH{1'b0}};
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sfifo_param.sv
// sfifo_param: parameterised synchronous FIFO with registered status and sticky errors.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sfifo_param_if slave (w_en/din/r_en/err_clr in; dout/dout_valid,
//          full/empty/almost_full/almost_empty/level, overflow/underflow out)
// Parameters: DWIDTH, DEPTH (power of two >= 4), AF_LEVEL, AE_LEVEL,
// IN_REG (1 = requests and data pass through a flop stage before use).
module sfifo_param
    import sfifo_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - AF_MARGIN_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF,
    parameter int IN_REG   = IN_REG_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sfifo_param_if.slave bus
);

    localparam int AW = clog2_f(DEPTH);
    localparam int LW = AW + 1;

    // Effective (post input-stage) requests
    logic              w_eff_s;
    logic              r_eff_s;
    logic [DWIDTH-1:0] din_eff_s;

    logic              do_wr_s;
    logic              do_rd_s;
    logic              ovf_set_s;
    logic              udf_set_s;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          dv_q, dv_d;

    if (IN_REG != 0) begin : g_in_reg
        logic              w_en_q;
        logic              r_en_q;
        logic [DWIDTH-1:0] din_q;

        // Input stage: requests and data take effect one cycle after the port.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                w_en_q <= 1'b0;
                r_en_q <= 1'b0;
                din_q  <= {DWIDTH{1'b0}};
            end else begin
                w_en_q <= bus.w_en;
                r_en_q <= bus.r_en;
                din_q  <= bus.din;
            end
        end

        assign w_eff_s   = w_en_q;
        assign r_eff_s   = r_en_q;
        assign din_eff_s = din_q;
    end else begin : g_no_in_reg
        assign w_eff_s   = bus.w_en;
        assign r_eff_s   = bus.r_en;
        assign din_eff_s = bus.din;
    end

    // Accept/reject decisions: a read frees a slot on the same edge, so a
    // write into a full FIFO is accepted when paired with a read.
    always_comb begin
        do_rd_s   = r_eff_s & ~empty_q;
        do_wr_s   = w_eff_s & (~full_q | r_eff_s);
        ovf_set_s = w_eff_s & full_q & ~r_eff_s;
        udf_set_s = r_eff_s & empty_q;
    end

    // Next-state for pointers, level, status and sticky flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        level_d = level_q + LW'(do_wr_s) - LW'(do_rd_s);
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == {LW{1'b0}});
        af_d    = (level_d >= LW'(AF_LEVEL));
        ae_d    = (level_d <= LW'(AE_LEVEL));
        dv_d    = do_rd_s;

        // Setting wins over a simultaneous clear.
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (bus.err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (udf_set_s) begin
            udf_d = 1'b1;
        end else if (bus.err_clr) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dv_q     <= dv_d;
        end
    end

    sfifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (do_wr_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (din_eff_s),
        .rd_en_i   (do_rd_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (bus.dout)
    );

    assign bus.dout_valid   = dv_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: directed self-checking bench for sfifo_param.
//   u_dut1 : default parameters (8 x 64, IN_REG=1)
//   u_dut2 : DWIDTH=16, DEPTH=8, IN_REG=0
module tb_sfifo_param;

    logic clk = 1'b0;
    logic rst1;
    logic rst2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sfifo_param_if #(.DWIDTH(8),  .DEPTH(64)) b1 ();
    sfifo_param_if #(.DWIDTH(16), .DEPTH(8))  b2 ();

    sfifo_param u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    sfifo_param #(
        .DWIDTH (16),
        .DEPTH  (8),
        .IN_REG (0)
    ) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (b2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DUT1 single write: two edges until it is effective (input stage + store).
    task automatic wr1(input logic [7:0] d);
        b1.w_en = 1'b1;
        b1.din  = d;
        tick();
        b1.w_en = 1'b0;
        tick();
    endtask

    // DUT1 single read: dout/dout_valid two edges after r_en at the port.
    task automatic rd1(input string tag, input logic [7:0] exp);
        b1.r_en = 1'b1;
        tick();
        b1.r_en = 1'b0;
        tick();
        check_eq({tag, "_dv"}, 32'(b1.dout_valid), 32'd1);
        check_eq(tag, 32'(b1.dout), 32'(exp));
    endtask

    // DUT2 single write: effective on the next edge.
    task automatic wr2(input logic [15:0] d);
        b2.w_en = 1'b1;
        b2.din  = d;
        tick();
        b2.w_en = 1'b0;
    endtask

    // DUT2 single read: data visible right after the first edge.
    task automatic rd2(input string tag, input logic [15:0] exp);
        b2.r_en = 1'b1;
        tick();
        b2.r_en = 1'b0;
        check_eq({tag, "_dv"}, 32'(b2.dout_valid), 32'd1);
        check_eq(tag, 32'(b2.dout), 32'(exp));
    endtask

    initial begin
        b1.w_en = 1'b0; b1.r_en = 1'b0; b1.din = 8'h00;  b1.err_clr = 1'b0;
        b2.w_en = 1'b0; b2.r_en = 1'b0; b2.din = 16'h0000; b2.err_clr = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_empty",  32'(b1.empty),        32'd1);
        check_eq("rst_full",   32'(b1.full),         32'd0);
        check_eq("rst_level",  32'(b1.level),        32'd0);
        check_eq("rst_ae",     32'(b1.almost_empty), 32'd1);
        check_eq("rst_af",     32'(b1.almost_full),  32'd0);
        check_eq("rst_dout",   32'(b1.dout),         32'd0);
        check_eq("rst_dv",     32'(b1.dout_valid),   32'd0);
        check_eq("rst_ovf",    32'(b1.overflow),     32'd0);
        check_eq("rst_udf",    32'(b1.underflow),    32'd0);
        check_eq("rst2_empty", 32'(b2.empty),        32'd1);
        rst1 = 1'b1;
        rst2 = 1'b1;

        // Fill 0x01..0x40; almost_full from level 60, almost_empty up to level 4
        for (int n = 1; n <= 64; n++) begin
            logic [7:0] d;
            d = 8'(n);
            wr1(d);
            check_eq("fill_level", 32'(b1.level),        32'(n));
            check_eq("fill_af",    32'(b1.almost_full),  (n >= 60) ? 32'd1 : 32'd0);
            check_eq("fill_ae",    32'(b1.almost_empty), (n <= 4)  ? 32'd1 : 32'd0);
        end
        check_eq("fill_full",  32'(b1.full),  32'd1);
        check_eq("fill_empty", 32'(b1.empty), 32'd0);

        // Overflow: extra write dropped, sticky until err_clr
        wr1(8'hAA);
        check_eq("ovf_set",   32'(b1.overflow), 32'd1);
        check_eq("ovf_level", 32'(b1.level),    32'd64);
        check_eq("ovf_full",  32'(b1.full),     32'd1);
        tick();
        check_eq("ovf_hold",  32'(b1.overflow), 32'd1);
        b1.err_clr = 1'b1;
        tick();
        b1.err_clr = 1'b0;
        check_eq("ovf_clr",   32'(b1.overflow), 32'd0);

        // Read+write while full: both performed, oldest word out
        b1.w_en = 1'b1;
        b1.r_en = 1'b1;
        b1.din  = 8'h77;
        tick();
        b1.w_en = 1'b0;
        b1.r_en = 1'b0;
        tick();
        check_eq("frw_level", 32'(b1.level),      32'd64);
        check_eq("frw_dv",    32'(b1.dout_valid), 32'd1);
        check_eq("frw_dout",  32'(b1.dout),       32'h01);
        check_eq("frw_ovf",   32'(b1.overflow),   32'd0);
        check_eq("frw_full",  32'(b1.full),       32'd1);
        tick();
        check_eq("frw_dv_pulse", 32'(b1.dout_valid), 32'd0);
        check_eq("frw_dout_hold", 32'(b1.dout),     32'h01);

        // Drain: 0x02..0x40 in order (0xAA never stored), then 0x77 last
        for (int n = 2; n <= 64; n++) begin
            logic [7:0] d;
            d = 8'(n);
            rd1("drain", d);
        end
        rd1("drain_last", 8'h77);
        check_eq("drain_empty", 32'(b1.empty),        32'd1);
        check_eq("drain_level", 32'(b1.level),        32'd0);
        check_eq("drain_ae",    32'(b1.almost_empty), 32'd1);
        check_eq("drain_udf",   32'(b1.underflow),    32'd0);

        // Read+write while empty: write only, underflow set, dout unchanged
        b1.w_en = 1'b1;
        b1.r_en = 1'b1;
        b1.din  = 8'h5C;
        tick();
        b1.w_en = 1'b0;
        b1.r_en = 1'b0;
        tick();
        check_eq("erw_level", 32'(b1.level),      32'd1);
        check_eq("erw_udf",   32'(b1.underflow),  32'd1);
        check_eq("erw_dv",    32'(b1.dout_valid), 32'd0);
        check_eq("erw_dout",  32'(b1.dout),       32'h77);
        rd1("erw_read", 8'h5C);
        b1.err_clr = 1'b1;
        tick();
        b1.err_clr = 1'b0;
        check_eq("udf_clr", 32'(b1.underflow), 32'd0);

        // Asynchronous reset mid-stream at level 10
        for (int n = 0; n < 10; n++) begin
            logic [7:0] d;
            d = 8'(8'h10 + n);
            wr1(d);
        end
        check_eq("mid_level", 32'(b1.level), 32'd10);
        b1.w_en = 1'b1;
        b1.din  = 8'hEE;
        #2;
        rst1 = 1'b0;
        #1;
        check_eq("arst_level", 32'(b1.level),        32'd0);
        check_eq("arst_empty", 32'(b1.empty),        32'd1);
        check_eq("arst_full",  32'(b1.full),         32'd0);
        check_eq("arst_ae",    32'(b1.almost_empty), 32'd1);
        check_eq("arst_dout",  32'(b1.dout),         32'd0);
        check_eq("arst_dv",    32'(b1.dout_valid),   32'd0);
        b1.w_en = 1'b0;
        tick();
        rst1 = 1'b1;
        b1.r_en = 1'b1;
        tick();
        b1.r_en = 1'b0;
        tick();
        check_eq("post_rst_udf",   32'(b1.underflow),  32'd1);
        check_eq("post_rst_dv",    32'(b1.dout_valid), 32'd0);
        check_eq("post_rst_level", 32'(b1.level),      32'd0);

        // DUT2: 16-bit, depth 8, no input stage; pointers wrap several times
        check_eq("d2_dv_idle", 32'(b2.dout_valid), 32'd0);
        wr2(16'h1000);
        check_eq("d2_lat_level", 32'(b2.level), 32'd1);
        wr2(16'h1001);
        wr2(16'h1002);
        for (int i = 0; i < 20; i++) begin
            logic [15:0] wd;
            logic [15:0] rd;
            wd = 16'(16'h1003 + i);
            rd = 16'(16'h1000 + i);
            wr2(wd);
            rd2("d2_wrap", rd);
        end
        check_eq("d2_level3", 32'(b2.level), 32'd3);
        for (int i = 0; i < 5; i++) begin
            logic [15:0] wd;
            wd = 16'(16'h2000 + i);
            wr2(wd);
        end
        check_eq("d2_full",  32'(b2.full),        32'd1);
        check_eq("d2_level", 32'(b2.level),       32'd8);
        check_eq("d2_af",    32'(b2.almost_full), 32'd1);
        wr2(16'hBEEF);
        check_eq("d2_ovf",   32'(b2.overflow),    32'd1);
        rd2("d2_after_ovf", 16'h1014);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
